// File: rtl/data_mem_mmio_ctrl.sv
// Data-memory + MMIO controller: byte-banked RAM with lane writes, LED/switch/button registers,
// req/ready handshake and misalignment flagging.
module data_mem_mmio_ctrl #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned LED_W   = 16,
    parameter int unsigned SW_W    = 16,
    parameter int unsigned DEB_CYC = 20000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        length,
    input  logic              sign,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              busy,
    output logic              misalign,
    input  logic [SW_W-1:0]   sw_in,
    input  logic              btn_in,
    output logic [LED_W-1:0]  led_out
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = $clog2(DEB_CYC + 1);

    typedef enum logic [1:0] {IDLE, RAM_RD, RESP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              misalign_q, misalign_d;
    logic [31:0]       led_q, led_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        len_q, len_d;
    logic              sgn_q, sgn_d;
    logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
    logic              btn_s1_q, btn_s2_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              flag_q, flag_d;

    logic              accept_c, mis_c, ram_we_c, ram_re_c, flag_set_c, addr_unused_c;
    logic [3:0]        be_c;
    logic [31:0]       lane_wdata_c, rd_word_c;
    logic [5:0]        woff_c;
    logic [ADDR_W-1:0] idx_c;

    // Shift the addressed lane(s) down and extend to 32 bits.
    function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] len, input logic sgn);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        if (len[1])
            return w;
        else if (len == 2'd1)
            return sgn ? {{16{s[15]}}, s[15:0]} : {16'h0000, s[15:0]};
        else
            return sgn ? {{24{s[7]}}, s[7:0]} : {24'h000000, s[7:0]};
    endfunction

    assign accept_c      = (state_q == IDLE) && req;
    assign mis_c         = ((length == 2'd1) && addr[0]) || (length[1] && (addr[1:0] != 2'b00));
    assign idx_c         = addr[ADDR_W+1:2];
    assign woff_c        = addr[7:2];
    assign ram_we_c      = accept_c && we && !addr[31] && !mis_c;
    assign ram_re_c      = accept_c && !we && !addr[31] && !mis_c;
    assign addr_unused_c = ^addr[30:0];

    always_comb begin
        be_c         = 4'b1111;
        lane_wdata_c = wdata;
        if (length == 2'd0) begin
            be_c         = 4'b0001 << addr[1:0];
            lane_wdata_c = {4{wdata[7:0]}};
        end else if (length == 2'd1) begin
            be_c         = addr[1] ? 4'b1100 : 4'b0011;
            lane_wdata_c = {2{wdata[15:0]}};
        end
    end

    // Four byte-wide banks with per-lane write enable and registered read.
    for (genvar l = 0; l < 4; l++) begin : g_bank
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;
        always_ff @(posedge clk) begin
            if (ram_we_c && be_c[l])
                mem[idx_c] <= lane_wdata_c[8*l +: 8];
            if (ram_re_c)
                rd_q <= mem[idx_c];
        end
        assign rd_word_c[8*l +: 8] = rd_q;
    end

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        misalign_d = misalign_q;
        led_d      = led_q;
        off_d      = off_q;
        len_d      = len_q;
        sgn_d      = sgn_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        flag_d     = flag_q;
        flag_set_c = 1'b0;

        // Debouncer: count consecutive cycles the synchronised input disagrees with the level.
        if (btn_s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_W'(DEB_CYC - 1)) begin
            level_d    = btn_s2_q;
            cnt_d      = '0;
            flag_set_c = btn_s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (req) begin
                    off_d      = addr[1:0];
                    len_d      = length;
                    sgn_d      = sign;
                    misalign_d = mis_c;
                    rdata_d    = '0;
                    state_d    = RESP;
                    ready_d    = 1'b1;
                    if (!mis_c && !addr[31] && !we) begin
                        state_d = RAM_RD;
                        ready_d = 1'b0;
                    end else if (!mis_c && addr[31]) begin
                        if (we) begin
                            if (woff_c == 6'h00) begin
                                for (int l = 0; l < 4; l++)
                                    if (be_c[l]) led_d[8*l +: 8] = lane_wdata_c[8*l +: 8];
                            end
                        end else begin
                            case (woff_c)
                                6'h00:   rdata_d = load_fmt(led_q, addr[1:0], length, sign);
                                6'h04:   rdata_d = load_fmt(32'(sw_s2_q), addr[1:0], length, sign);
                                6'h08: begin
                                    rdata_d = load_fmt({30'd0, flag_q, level_q}, addr[1:0],
                                                       length, sign);
                                    flag_d  = 1'b0;
                                end
                                default: rdata_d = '0;
                            endcase
                        end
                    end
                end
            end
            RAM_RD: begin
                rdata_d = load_fmt(rd_word_c, off_q, len_q, sgn_q);
                state_d = RESP;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (flag_set_c)
            flag_d = 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            misalign_q <= 1'b0;
            led_q      <= '0;
            off_q      <= '0;
            len_q      <= '0;
            sgn_q      <= 1'b0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            misalign_q <= misalign_d;
            led_q      <= led_d;
            off_q      <= off_d;
            len_q      <= len_d;
            sgn_q      <= sgn_d;
            sw_s1_q    <= sw_in;
            sw_s2_q    <= sw_s1_q;
            btn_s1_q   <= btn_in;
            btn_s2_q   <= btn_s1_q;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            flag_q     <= flag_d;
        end
    end

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign misalign = misalign_q;
    assign led_out  = led_q[LED_W-1:0];

endmodule

// File: tb/tb_data_mem_mmio_ctrl.sv
// Scoreboard bench for data_mem_mmio_ctrl: directed accesses push expectations, a monitor
// compares on every ready pulse.
module tb_data_mem_mmio_ctrl;

    localparam int unsigned DEB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, sign = 1'b0, btn_in = 1'b0;
    logic [1:0]  length = 2'd0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        ready, busy, misalign;
    logic [15:0] sw_in = '0, led_out;
    logic [31:0] cyc = '0;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];

    data_mem_mmio_ctrl #(.ADDR_W(10), .LED_W(16), .SW_W(16), .DEB_CYC(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .length(length), .sign(sign),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
        .misalign(misalign), .sw_in(sw_in), .btn_in(btn_in), .led_out(led_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        compared++;
        if (act !== req_v) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req_v);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_ready: rdata 0x%08h with empty scoreboard", rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rdata", rdata, e.rdata);
                chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
                chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one access at a negedge; returns at the negedge after the ready pulse.
    task automatic acc(input logic w, input logic [1:0] len, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_mis);
        exp_t e;
        int n;
        e.rdata = exp_rd;
        e.mis   = exp_mis;
        e.cyc   = cyc + ((!exp_mis && !a[31] && !w) ? 32'd2 : 32'd1);
        exp_q.push_back(e);
        req = 1'b1; we = w; length = len; sign = sg; addr = a; wdata = wd;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (!ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout: no ready for addr 0x%08h", a);
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", {31'd0, ready}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_misalign", {31'd0, misalign}, 32'h0);
        chk("rst_led", {16'd0, led_out}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // RAM word store/load and byte lanes
        acc(1, 2'd2, 0, 32'h100, 32'h12345678, 32'h0, 0);
        acc(0, 2'd2, 0, 32'h100, 32'h0, 32'h12345678, 0);
        acc(1, 2'd0, 0, 32'h101, 32'h00000080, 32'h0, 0);
        acc(0, 2'd0, 1, 32'h101, 32'h0, 32'hFFFFFF80, 0);
        acc(0, 2'd0, 0, 32'h101, 32'h0, 32'h00000080, 0);
        acc(0, 2'd2, 0, 32'h100, 32'h0, 32'h12348078, 0);
        acc(0, 2'd1, 1, 32'h102, 32'h0, 32'h00001234, 0);
        acc(0, 2'd1, 1, 32'h100, 32'h0, 32'hFFFF8078, 0);
        acc(0, 2'd1, 0, 32'h100, 32'h0, 32'h00008078, 0);
        acc(1, 2'd3, 0, 32'h104, 32'hA1B2C3D4, 32'h0, 0);
        acc(0, 2'd0, 0, 32'h107, 32'h0, 32'h000000A1, 0);

        // Misaligned accesses are rejected without side effects
        acc(0, 2'd1, 1, 32'h103, 32'h0, 32'h0, 1);
        acc(1, 2'd2, 0, 32'h102, 32'hFFFFFFFF, 32'h0, 1);
        acc(1, 2'd2, 0, 32'h80000002, 32'h0000FFFF, 32'h0, 1);
        acc(0, 2'd2, 0, 32'h100, 32'h0, 32'h12348078, 0);
        chk("led_after_misalign", {16'd0, led_out}, 32'h0);

        // MMIO LED / switches / unmapped
        acc(1, 2'd1, 0, 32'h80000002, 32'h0000BEEF, 32'h0, 0);
        chk("led_upper_lanes", {16'd0, led_out}, 32'h0);
        acc(1, 2'd1, 0, 32'h80000000, 32'h0000A5A5, 32'h0, 0);
        chk("led_a5a5", {16'd0, led_out}, 32'h0000A5A5);
        acc(0, 2'd0, 1, 32'h80000000, 32'h0, 32'hFFFFFFA5, 0);
        acc(0, 2'd1, 0, 32'h80000000, 32'h0, 32'h0000A5A5, 0);
        acc(1, 2'd2, 0, 32'h80000010, 32'h12345678, 32'h0, 0);
        sw_in = 16'h00F0;
        repeat (3) @(negedge clk);
        acc(0, 2'd2, 0, 32'h80000010, 32'h0, 32'h000000F0, 0);
        acc(0, 2'd2, 0, 32'h80000040, 32'h0, 32'h0, 0);
        chk("led_hold", {16'd0, led_out}, 32'h0000A5A5);

        // Debounce: one cycle short of the threshold, then long enough
        btn_in = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        btn_in = 1'b0;
        repeat (DEB + 4) @(negedge clk);
        acc(0, 2'd2, 0, 32'h80000020, 32'h0, 32'h0, 0);
        btn_in = 1'b1;
        repeat (DEB + 5) @(negedge clk);
        acc(0, 2'd2, 0, 32'h80000020, 32'h0, 32'h3, 0);
        acc(0, 2'd2, 0, 32'h80000020, 32'h0, 32'h1, 0);

        // Reset while in RAM_RD aborts the access
        req = 1'b1; we = 1'b0; length = 2'd2; addr = 32'h100;
        @(negedge clk);
        req = 1'b0;
        chk("in_ram_rd_busy", {31'd0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'h0);
        chk("abort_ready", {31'd0, ready}, 32'h0);
        chk("abort_led", {16'd0, led_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Request during RESP is ignored, then back-to-back accesses complete in order
        begin
            exp_t e;
            e.rdata = 32'h0; e.mis = 1'b0; e.cyc = cyc + 32'd1;
            exp_q.push_back(e);
            req = 1'b1; we = 1'b1; length = 2'd2; addr = 32'h200; wdata = 32'hCAFEF00D;
            @(negedge clk);
            chk("resp_busy", {31'd0, busy}, 32'h1);
            wdata = 32'hDEADBEEF;
            @(negedge clk);
            req = 1'b0;
        end
        acc(0, 2'd2, 0, 32'h200, 32'h0, 32'hCAFEF00D, 0);
        acc(1, 2'd0, 0, 32'h203, 32'h00000011, 32'h0, 0);
        acc(0, 2'd2, 0, 32'h200, 32'h0, 32'h11FEF00D, 0);
        acc(0, 2'd2, 0, 32'h104, 32'h0, 32'hA1B2C3D4, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
